// File: rtl/hex_display_pkg.sv
// Shared definitions for the GPIO hex/decimal display.
//   state_e      : controller states (idle, double-dabble shift, segment update)
//   NUM_DIGITS   : number of seven-segment digits driven
//   BCD_DIGITS   : BCD accumulator width in nibbles (covers 2^32-1)
//   SHIFT_CYCLES : double-dabble iterations for a 32-bit operand
//   SEG_BLANK    : all-segments-off pattern in active-low form
//   SEG_TABLE    : active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
package hex_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StUpdate
  } state_e;

  localparam int unsigned NUM_DIGITS   = 8;
  localparam int unsigned BCD_DIGITS   = 10;
  localparam int unsigned SHIFT_CYCLES = 32;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 is leftmost in the pattern below.
  localparam logic [15:0][6:0] SEG_TABLE = '{
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder for one digit.
//   digit : 4-bit hex digit
//   blank : 1 forces all segments off
//   seg   : {g,f,e,d,c,b,a}, active-low when SEG_ACTIVE_LOW=1, else inverted
module seg7_decode
  import hex_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = blank ? SEG_BLANK : SEG_TABLE[digit];
    seg     = SEG_ACTIVE_LOW ? pattern : ~pattern;
  end

endmodule

// File: rtl/gpio_hex_display.sv
// Eight-digit seven-segment driver for a CPU GPIO word.
// Captures {value, hex_mode} whenever it changes while idle, converts to BCD by
// double-dabble in decimal mode, then loads all segment registers at once.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   value     : 32-bit word to display
//   hex_mode  : 1 = hexadecimal, 0 = unsigned decimal
//   hex0..7   : registered segment patterns, hex0 least significant
//   busy      : registered, high during conversion/update
//   overflow  : registered, decimal value needs more than 8 digits
module gpio_hex_display
  import hex_display_pkg::*;
#(
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        hex_mode,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy,
  output logic        overflow
);

  localparam logic [6:0] BLANK_CODE = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_e                         state_q, state_d;
  logic [5:0]                     cnt_q, cnt_d;
  logic [4*BCD_DIGITS-1:0]        bcd_q, bcd_d;
  logic [31:0]                    bin_q, bin_d;
  logic [31:0]                    value_q, value_d;
  logic                           mode_q, mode_d;
  logic                           valid_q, valid_d;
  logic [NUM_DIGITS-1:0][6:0]     hex_q, hex_d;
  logic                           ovf_q, ovf_d;
  logic                           busy_q, busy_d;

  logic [4*BCD_DIGITS-1:0]        bcd_adj;
  logic [NUM_DIGITS-1:0][3:0]     digit;
  logic [NUM_DIGITS-1:0]          blank;
  logic [NUM_DIGITS-1:0][6:0]     seg;
  logic                           ovf_now;
  logic                           blank_en;
  logic                           above_zero;

  // Double-dabble correction: bias every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(BCD_DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Digit selection and leading-zero blanking from the captured data.
  always_comb begin
    digit      = mode_q ? value_q : bcd_q[31:0];
    ovf_now    = !mode_q && (bcd_q[39:32] != '0);
    blank_en   = BLANK_LZ && !ovf_now;
    above_zero = 1'b1;
    blank      = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      above_zero = above_zero && (digit[i] == 4'd0);
      blank[i]   = blank_en && above_zero;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .digit(digit[g]),
      .blank(blank[g]),
      .seg  (seg[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    value_d = value_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (!valid_q || (value != value_q) || (hex_mode != mode_q)) begin
          value_d = value;
          mode_d  = hex_mode;
          valid_d = 1'b1;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = hex_mode ? StUpdate : StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[4*BCD_DIGITS-2:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(SHIFT_CYCLES - 1)) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        hex_d   = seg;
        ovf_d   = ovf_now;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      value_q <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      hex_q   <= {NUM_DIGITS{BLANK_CODE}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      value_q <= value_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign hex6     = hex_q[6];
  assign hex7     = hex_q[7];
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
